// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: FSM states, shift modes,
// operand sources and shift-amount sources.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SRC_IMM4  = 2'b00,
        SRC_IMM8  = 2'b01,
        SRC_REG_A = 2'b10,
        SRC_ALU   = 2'b11
    } src_sel_e;

    typedef enum logic [1:0] {
        AMT_ONE  = 2'b00,
        AMT_IMM4 = 2'b01,
        AMT_ZERO = 2'b10,
        AMT_FOUR = 2'b11
    } amt_sel_e;

endpackage

// File: rtl/shift_operand_mux.sv
// Combinational operand and shift-amount selection, including Imm4 zero
// extension and Imm8 sign extension to the datapath width.
module shift_operand_mux
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  src_sel_e               src_sel_i,
    input  amt_sel_e               amt_sel_i,
    input  logic [3:0]             imm4_i,
    input  logic [7:0]             imm8_i,
    input  logic [WIDTH-1:0]       reg_a_i,
    input  logic [WIDTH-1:0]       alu_out_i,
    output logic [WIDTH-1:0]       operand_o,
    output logic [AMT_W-1:0]       amount_o
);

    always_comb begin
        operand_o = '0;
        unique case (src_sel_i)
            SRC_IMM4:  operand_o = WIDTH'(imm4_i);
            SRC_IMM8:  operand_o = WIDTH'($signed(imm8_i));
            SRC_REG_A: operand_o = reg_a_i;
            SRC_ALU:   operand_o = alu_out_i;
            default:   operand_o = '0;
        endcase
    end

    always_comb begin
        amount_o = '0;
        unique case (amt_sel_i)
            AMT_ONE:  amount_o = AMT_W'(1);
            AMT_IMM4: amount_o = AMT_W'(imm4_i);
            AMT_ZERO: amount_o = '0;
            AMT_FOUR: amount_o = AMT_W'(4);
            default:  amount_o = '0;
        endcase
    end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: captures an operand, amount and mode on Start, then
// applies one 1-bit step per cycle until the amount is exhausted.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for start_i; captures operand/amount/mode on it
//   ST_SHIFT | one 1-bit step per cycle, counter decrements to zero
//   ST_DONE  | done_o pulse for one cycle, result_o stable
module iterative_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         src_sel_i,
    input  logic [1:0]         amt_sel_i,
    input  logic [1:0]         mode_i,
    input  logic [3:0]         imm4_i,
    input  logic [7:0]         imm8_i,
    input  logic [WIDTH-1:0]   reg_a_i,
    input  logic [WIDTH-1:0]   alu_out_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   result_o
);

    state_e             state_q, state_d;
    mode_e              mode_q,  mode_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [AMT_W-1:0]   cnt_q,   cnt_d;

    logic [WIDTH-1:0]   operand;
    logic [AMT_W-1:0]   amount;

    shift_operand_mux #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_operand_mux (
        .src_sel_i (src_sel_e'(src_sel_i)),
        .amt_sel_i (amt_sel_e'(amt_sel_i)),
        .imm4_i    (imm4_i),
        .imm8_i    (imm8_i),
        .reg_a_i   (reg_a_i),
        .alu_out_i (alu_out_i),
        .operand_o (operand),
        .amount_o  (amount)
    );

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                    input mode_e m);
        logic [WIDTH-1:0] r;
        r = v;
        unique case (m)
            MODE_LSL: r = {v[WIDTH-2:0], 1'b0};
            MODE_LSR: r = {1'b0, v[WIDTH-1:1]};
            MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
            MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            default:  r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_DONE);

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    result_d = operand;
                    cnt_d    = amount;
                    mode_d   = mode_e'(mode_i);
                    state_d  = (amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                result_d = shift_step(result_q, mode_q);
                cnt_d    = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_LSL;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: latency, results, busy handling,
// start-held behaviour and asynchronous reset mid-operation.
module tb_iterative_shift_unit;
    import shift_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  src_sel_i = 2'b00;
    logic [1:0]  amt_sel_i = 2'b00;
    logic [1:0]  mode_i = 2'b00;
    logic [3:0]  imm4_i = 4'h0;
    logic [7:0]  imm8_i = 8'h00;
    logic [15:0] reg_a_i = 16'h0000;
    logic [15:0] alu_out_i = 16'h0000;
    logic        busy_o;
    logic        done_o;
    logic [15:0] result_o;

    int n_chk = 0;
    int n_bad = 0;

    iterative_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .src_sel_i (src_sel_i),
        .amt_sel_i (amt_sel_i),
        .mode_i    (mode_i),
        .imm4_i    (imm4_i),
        .imm8_i    (imm8_i),
        .reg_a_i   (reg_a_i),
        .alu_out_i (alu_out_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and measure cycles from the accepting edge to Done.
    task automatic run_op(input string tag, input logic [1:0] src, input logic [1:0] amt,
                          input logic [1:0] mode, input logic [3:0] imm4, input logic [7:0] imm8,
                          input logic [15:0] exp_res, input int exp_lat, input bit disturb);
        int lat;
        int busy_n;
        @(negedge clk_i);
        src_sel_i = src; amt_sel_i = amt; mode_i = mode; imm4_i = imm4; imm8_i = imm8;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = 1;
        busy_n = 0;
        forever begin
            if (busy_o) busy_n++;
            if (done_o || lat >= 40) break;
            if (disturb) begin
                start_i   = 1'b1;
                mode_i    = MODE_LSL;
                src_sel_i = SRC_REG_A;
                amt_sel_i = AMT_ONE;
                reg_a_i   = 16'h5A5A ^ 16'(lat);
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " busy cycles"}, busy_n, exp_lat);
        @(posedge clk_i); #1;
        chk({tag, " done single"}, done_o, 1'b0);
        chk({tag, " busy clear"}, busy_o, 1'b0);
        chk({tag, " result held"}, result_o, exp_res);
    endtask

    initial begin
        int dn;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset busy", busy_o, 1'b0);
        chk("reset done", done_o, 1'b0);
        chk("reset result", result_o, 16'h0000);
        rst_i = 1'b0;

        // First op right on the first edge after reset release.
        run_op("imm8 asr1", SRC_IMM8, AMT_IMM4, MODE_ASR, 4'h1, 8'h81, 16'hFFC0, 2, 1'b0);
        run_op("imm8 lsl4", SRC_IMM8, AMT_FOUR, MODE_LSL, 4'h0, 8'h81, 16'hF810, 5, 1'b0);
        run_op("imm8 amt0", SRC_IMM8, AMT_ZERO, MODE_LSL, 4'h0, 8'h81, 16'hFF81, 1, 1'b0);
        alu_out_i = 16'h0F0F;
        run_op("alu lsl1", SRC_ALU, AMT_ONE, MODE_LSL, 4'h0, 8'h00, 16'h1E1E, 2, 1'b0);
        reg_a_i = 16'h8001;
        run_op("rega rol1", SRC_REG_A, AMT_ONE, MODE_ROL, 4'h0, 8'h00, 16'h0003, 2, 1'b0);
        run_op("imm4 rol4", SRC_IMM4, AMT_FOUR, MODE_ROL, 4'hA, 8'h00, 16'h00A0, 5, 1'b0);
        run_op("imm8 asr15", SRC_IMM8, AMT_IMM4, MODE_ASR, 4'hF, 8'h80, 16'hFFFF, 16, 1'b0);
        reg_a_i = 16'h8001;
        run_op("rega lsr15", SRC_REG_A, AMT_IMM4, MODE_LSR, 4'hF, 8'h00, 16'h0001, 16, 1'b1);

        // Start held high with zero amount: accept, done, accept, done ...
        @(negedge clk_i);
        src_sel_i = SRC_IMM4; amt_sel_i = AMT_ZERO; mode_i = MODE_LSL; imm4_i = 4'h7;
        start_i = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (done_o) dn++;
        end
        start_i = 1'b0;
        chk("held start dones", dn, 3);
        chk("held start result", result_o, 16'h0007);
        repeat (2) @(posedge clk_i);

        // Asynchronous reset in the middle of a 15-step shift.
        @(negedge clk_i);
        reg_a_i = 16'h8001; src_sel_i = SRC_REG_A; amt_sel_i = AMT_IMM4;
        mode_i = MODE_LSR; imm4_i = 4'hF;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        chk("pre-reset busy", busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("async rst busy", busy_o, 1'b0);
        chk("async rst done", done_o, 1'b0);
        chk("async rst result", result_o, 16'h0000);
        @(negedge clk_i);
        rst_i = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) dn++;
        end
        chk("no done after reset", dn, 0);

        run_op("post-reset imm4 lsl1", SRC_IMM4, AMT_ONE, MODE_LSL, 4'h3, 8'h00, 16'h0006, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
